// File: rtl/alu_exec_unit.sv
// Execute unit: single-cycle ADD/SUB, iterative shift-add MUL and restoring DIV.
// Holds one operation at a time behind a valid/ready handshake on each side.
module alu_exec_unit #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op_opcode,
  input  logic [DATA_W-1:0] rs1_reg_val,
  input  logic [DATA_W-1:0] rs2_reg_val,
  input  logic [TAG_W-1:0]  rd_tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [TAG_W-1:0]  rd_tag_out,
  output logic              div_by_zero
);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mul_nxt;
  logic [2*DATA_W-1:0] div_nxt;
  logic              last_iter;

  function automatic logic [DATA_W-1:0] mul_step(input logic [DATA_W-1:0] acc_in,
                                                  input logic [DATA_W-1:0] mcand,
                                                  input logic              mbit);
    return mbit ? acc_in + mcand : acc_in;
  endfunction

  // Returns {remainder, quotient} after one restoring step.
  function automatic logic [2*DATA_W-1:0] div_step(input logic [DATA_W-1:0] rem,
                                                    input logic [DATA_W-1:0] quo,
                                                    input logic [DATA_W-1:0] dvsr);
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;
    shifted = {rem, quo[DATA_W-1]};
    trial   = shifted - {1'b0, dvsr};
    if (trial[DATA_W]) return {shifted[DATA_W-1:0], quo[DATA_W-2:0], 1'b0};
    return {trial[DATA_W-1:0], quo[DATA_W-2:0], 1'b1};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last_iter = (cnt == CNT_LAST);
  assign mul_nxt   = mul_step(acc, opa, opb[0]);
  assign div_nxt   = div_step(acc, opa, opb);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          case (op_opcode)
            OP_MUL:  state_nxt = MUL;
            OP_DIV:  state_nxt = (rs2_reg_val == '0) ? DONE : DIV;
            default: state_nxt = DONE;
          endcase
        end
      end
      MUL, DIV: if (last_iter) state_nxt = DONE;
      DONE:     if (out_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand latch at accept, one MUL/DIV iteration per cycle, result held through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      opa         <= '0;
      opb         <= '0;
      acc         <= '0;
      result      <= '0;
      rd_tag_out  <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt         <= '0;
            acc         <= '0;
            opa         <= rs1_reg_val;
            opb         <= rs2_reg_val;
            rd_tag_out  <= rd_tag_in;
            div_by_zero <= 1'b0;
            case (op_opcode)
              OP_ADD: result <= rs1_reg_val + rs2_reg_val;
              OP_SUB: result <= rs1_reg_val - rs2_reg_val;
              OP_DIV: begin
                if (rs2_reg_val == '0) begin
                  result      <= '1;
                  div_by_zero <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          acc <= mul_nxt;
          opa <= opa << 1;
          opb <= opb >> 1;
          cnt <= cnt + CNT_W'(1);
          if (last_iter) result <= mul_nxt;
        end
        DIV: begin
          {acc, opa} <= div_nxt;
          cnt        <= cnt + CNT_W'(1);
          if (last_iter) result <= div_nxt[DATA_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results are queued at issue
// and popped when out_valid appears.
module tb_alu_exec_unit;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;
  localparam int TMO    = 200;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        op_opcode;
  logic [DATA_W-1:0] rs1_reg_val;
  logic [DATA_W-1:0] rs2_reg_val;
  logic [TAG_W-1:0]  rd_tag_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic [TAG_W-1:0]  rd_tag_out;
  logic              div_by_zero;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  tag;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_opcode(op_opcode), .rs1_reg_val(rs1_reg_val), .rs2_reg_val(rs2_reg_val),
    .rd_tag_in(rd_tag_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .rd_tag_out(rd_tag_out), .div_by_zero(div_by_zero)
  );

  function automatic exp_t model(input logic [1:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [2:0] tag);
    exp_t e;
    logic [31:0] p;
    e.tag = tag; e.dbz = 1'b0; e.lat = 0; e.res = '0;
    p = 32'(a) * 32'(b);
    case (op)
      2'd0: e.res = a + b;
      2'd1: e.res = a - b;
      2'd2: begin e.res = p[15:0]; e.lat = 16; end
      default: begin
        if (b == 16'd0) begin e.res = 16'hFFFF; e.dbz = 1'b1; end
        else begin e.res = a / b; e.lat = 16; end
      end
    endcase
    return e;
  endfunction

  // Present an op, wait for acceptance, queue its expectation, then scramble inputs.
  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] tag);
    int w = 0;
    @(negedge clk);
    op_opcode = op; rs1_reg_val = a; rs2_reg_val = b; rd_tag_in = tag; in_valid = 1'b1;
    while (in_ready !== 1'b1) begin
      if (w >= TMO) begin
        $display("FAIL send_timeout: in_ready stayed %b for %0d cycles, need 1", in_ready, w);
        $fatal(1, "accept timeout");
      end
      @(negedge clk); w++;
    end
    sb.push_back(model(op, a, b, tag));
    @(negedge clk);
    in_valid    = 1'b0;
    op_opcode   = 2'($urandom);
    rs1_reg_val = 16'($urandom);
    rs2_reg_val = 16'($urandom);
    rd_tag_in   = 3'($urandom);
  endtask

  // Wait (bounded) for out_valid; k counts edges after the accept edge.
  task automatic collect(output logic [15:0] r, output logic [2:0] t, output logic d,
                         output int k, output bit rdy_seen);
    k = 0; rdy_seen = 1'b0;
    while (out_valid !== 1'b1) begin
      if (in_ready === 1'b1) rdy_seen = 1'b1;
      if (k >= TMO) begin
        $display("FAIL collect_timeout: out_valid stayed %b for %0d cycles, need 1", out_valid, k);
        $fatal(1, "result timeout");
      end
      @(negedge clk); k++;
    end
    r = result; t = rd_tag_out; d = div_by_zero;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b need 0", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 16'h0000) $display("FAIL rst_result: got %h need 0000", result); else pass_cnt++;
    total_cnt++; if (rd_tag_out !== 3'd0) $display("FAIL rst_tag: got %0d need 0", rd_tag_out); else pass_cnt++;
    total_cnt++; if (div_by_zero !== 1'b0) $display("FAIL rst_dbz: got %b need 0", div_by_zero); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b need 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_add_sub;
    logic [15:0] r; logic [2:0] t; logic d; int k; bit rs; exp_t e;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] op; logic [15:0] a, b; logic [2:0] tg;
      case (i)
        0: begin op = 2'd0; a = 16'hFFFF; b = 16'h0002; tg = 3'd5; end
        1: begin op = 2'd1; a = 16'h0003; b = 16'h0005; tg = 3'd1; end
        default: begin op = 2'(i & 1); a = 16'($urandom); b = 16'($urandom); tg = 3'($urandom); end
      endcase
      send(op, a, b, tg);
      collect(r, t, d, k, rs);
      e = sb.pop_front();
      total_cnt++; if (r !== e.res) $display("FAIL addsub_result[%0d]: got %h need %h", i, r, e.res); else pass_cnt++;
      total_cnt++; if (t !== e.tag) $display("FAIL addsub_tag[%0d]: got %0d need %0d", i, t, e.tag); else pass_cnt++;
      total_cnt++; if (d !== 1'b0) $display("FAIL addsub_dbz[%0d]: got %b need 0", i, d); else pass_cnt++;
      total_cnt++; if (k !== e.lat) $display("FAIL addsub_latency[%0d]: got %0d need %0d", i, k, e.lat); else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL addsub_release[%0d]: got out_valid=%b in_ready=%b need 0/1", i, out_valid, in_ready);
      else pass_cnt++;
    end
  endtask

  task automatic test_mul;
    logic [15:0] r; logic [2:0] t; logic d; int k; bit rs; exp_t e;
    for (int i = 0; i < 5; i++) begin
      logic [15:0] a, b;
      case (i)
        0: begin a = 16'h0123; b = 16'h0045; end
        1: begin a = 16'hFFFF; b = 16'hFFFF; end
        default: begin a = 16'($urandom); b = 16'($urandom); end
      endcase
      send(2'd2, a, b, 3'(i + 2));
      collect(r, t, d, k, rs);
      e = sb.pop_front();
      total_cnt++; if (r !== e.res) $display("FAIL mul_result[%0d]: got %h need %h", i, r, e.res); else pass_cnt++;
      total_cnt++; if (t !== e.tag) $display("FAIL mul_tag[%0d]: got %0d need %0d", i, t, e.tag); else pass_cnt++;
      total_cnt++; if (d !== 1'b0) $display("FAIL mul_dbz[%0d]: got %b need 0", i, d); else pass_cnt++;
      total_cnt++; if (k !== 16) $display("FAIL mul_latency[%0d]: got %0d need 16", i, k); else pass_cnt++;
      total_cnt++; if (rs !== 1'b0) $display("FAIL mul_busy_ready[%0d]: in_ready seen %b need 0", i, rs); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL mul_release[%0d]: got in_ready=%b need 1", i, in_ready); else pass_cnt++;
    end
  endtask

  task automatic test_div;
    logic [15:0] r; logic [2:0] t; logic d; int k; bit rs; exp_t e;
    for (int i = 0; i < 6; i++) begin
      logic [15:0] a, b;
      case (i)
        0: begin a = 16'd1000; b = 16'd7; end
        1: begin a = 16'd5;    b = 16'd9; end
        2: begin a = 16'hFFFF; b = 16'd1; end
        default: begin a = 16'($urandom); b = 16'($urandom_range(1, 65535)); end
      endcase
      send(2'd3, a, b, 3'(7 - i));
      collect(r, t, d, k, rs);
      e = sb.pop_front();
      total_cnt++; if (r !== e.res) $display("FAIL div_result[%0d]: got %h need %h", i, r, e.res); else pass_cnt++;
      total_cnt++; if (t !== e.tag) $display("FAIL div_tag[%0d]: got %0d need %0d", i, t, e.tag); else pass_cnt++;
      total_cnt++; if (d !== 1'b0) $display("FAIL div_dbz[%0d]: got %b need 0", i, d); else pass_cnt++;
      total_cnt++; if (k !== 16) $display("FAIL div_latency[%0d]: got %0d need 16", i, k); else pass_cnt++;
      total_cnt++; if (rs !== 1'b0) $display("FAIL div_busy_ready[%0d]: in_ready seen %b need 0", i, rs); else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero;
    logic [15:0] r; logic [2:0] t; logic d; int k; bit rs; exp_t e;
    send(2'd3, 16'h1234, 16'h0000, 3'd4);
    collect(r, t, d, k, rs);
    e = sb.pop_front();
    total_cnt++; if (r !== 16'hFFFF) $display("FAIL dz_result: got %h need ffff", r); else pass_cnt++;
    total_cnt++; if (d !== 1'b1) $display("FAIL dz_flag: got %b need 1", d); else pass_cnt++;
    total_cnt++; if (t !== e.tag) $display("FAIL dz_tag: got %0d need %0d", t, e.tag); else pass_cnt++;
    total_cnt++; if (k !== 0) $display("FAIL dz_latency: got %0d need 0", k); else pass_cnt++;
    @(negedge clk);
    send(2'd0, 16'd1, 16'd1, 3'd2);
    collect(r, t, d, k, rs);
    e = sb.pop_front();
    total_cnt++; if (r !== 16'd2) $display("FAIL dz_next_result: got %h need 0002", r); else pass_cnt++;
    total_cnt++; if (d !== 1'b0) $display("FAIL dz_next_flag: got %b need 0", d); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [15:0] r; logic [2:0] t; logic d; int k; bit rs; exp_t e; int stray;
    out_ready = 1'b0;
    send(2'd2, 16'd3, 16'd4, 3'd6);
    collect(r, t, d, k, rs);
    e = sb.pop_front();
    for (int j = 0; j < 10; j++) begin
      total_cnt++;
      if (out_valid !== 1'b1 || result !== 16'h000C || rd_tag_out !== e.tag || div_by_zero !== 1'b0)
        $display("FAIL bp_hold[%0d]: got v=%b r=%h t=%0d dz=%b need 1/000c/%0d/0",
                 j, out_valid, result, rd_tag_out, div_by_zero, e.tag);
      else pass_cnt++;
      in_valid = (j % 2 == 0) && (j < 9);
      op_opcode = 2'd0; rs1_reg_val = 16'h0100; rs2_reg_val = 16'h0200; rd_tag_in = 3'd1;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release: got out_valid=%b in_ready=%b need 0/1", out_valid, in_ready);
    else pass_cnt++;
    stray = 0;
    repeat (4) begin @(negedge clk); if (out_valid !== 1'b0) stray++; end
    total_cnt++; if (stray !== 0) $display("FAIL bp_ignored_input: got %0d valid cycles need 0", stray); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    @(negedge clk);
    op_opcode = 2'd0; rs1_reg_val = 16'd10; rs2_reg_val = 16'd20; rd_tag_in = 3'd1; in_valid = 1'b1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_idle_ready: got %b need 1", in_ready); else pass_cnt++;
    sb.push_back(model(2'd0, 16'd10, 16'd20, 3'd1));
    @(negedge clk);
    e = sb.pop_front();
    total_cnt++;
    if (out_valid !== 1'b1 || result !== e.res || rd_tag_out !== e.tag || in_ready !== 1'b0)
      $display("FAIL b2b_first: got v=%b r=%h t=%0d rdy=%b need 1/%h/%0d/0", out_valid, result, rd_tag_out, in_ready, e.res, e.tag);
    else pass_cnt++;
    op_opcode = 2'd1; rs1_reg_val = 16'd5; rs2_reg_val = 16'd6; rd_tag_in = 3'd2;
    sb.push_back(model(2'd1, 16'd5, 16'd6, 3'd2));
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL b2b_gap: got out_valid=%b in_ready=%b need 0/1", out_valid, in_ready);
    else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0;
    e = sb.pop_front();
    total_cnt++;
    if (out_valid !== 1'b1 || result !== e.res || rd_tag_out !== e.tag)
      $display("FAIL b2b_second: got v=%b r=%h t=%0d need 1/%h/%0d", out_valid, result, rd_tag_out, e.res, e.tag);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    logic [15:0] r; logic [2:0] t; logic d; int k; bit rs; exp_t e; int stray;
    send(2'd0, 16'd7, 16'd9, 3'd7);
    collect(r, t, d, k, rs);
    e = sb.pop_front();
    total_cnt++; if (r !== 16'd16) $display("FAIL rmid_pre_result: got %h need 0010", r); else pass_cnt++;
    @(negedge clk);
    send(2'd2, 16'h1234, 16'h5678, 3'd6);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || result !== 16'h0000 || rd_tag_out !== 3'd0 || div_by_zero !== 1'b0)
      $display("FAIL rmid_clear: got v=%b r=%h t=%0d dz=%b need 0/0000/0/0", out_valid, result, rd_tag_out, div_by_zero);
    else pass_cnt++;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rmid_in_ready: got %b need 1", in_ready); else pass_cnt++;
    stray = 0;
    repeat (20) begin @(negedge clk); if (out_valid !== 1'b0) stray++; end
    total_cnt++; if (stray !== 0) $display("FAIL rmid_no_residue: got %0d valid cycles need 0", stray); else pass_cnt++;
    send(2'd0, 16'd2, 16'd3, 3'd3);
    collect(r, t, d, k, rs);
    e = sb.pop_front();
    total_cnt++; if (r !== 16'd5) $display("FAIL rmid_add_result: got %h need 0005", r); else pass_cnt++;
    total_cnt++; if (t !== 3'd3) $display("FAIL rmid_add_tag: got %0d need 3", t); else pass_cnt++;
    total_cnt++; if (k !== 0) $display("FAIL rmid_add_latency: got %0d need 0", k); else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op_opcode = 2'd0;
    rs1_reg_val = '0; rs2_reg_val = '0; rd_tag_in = '0;
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_div_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute stage directly downstream of the rs2 operand router; consumes one operation (opcode, rs1 value, rs2 value, destination tag) and produces one result.
- ADD/SUB complete in a single cycle. MUL uses an iterative shift-add datapath and DIV uses iterative restoring division.
- Handshakes on both sides let decode stall on a busy unit and let writeback apply back-pressure.
- One operation in flight at a time.

Parameters:
- DATA_W, 16, operand/result width in bits.
- TAG_W, 3, destination register tag width; the tag passes through unchanged.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit can accept; equal to (state==IDLE).
- op_opcode  input  2  0=ADD, 1=SUB, 2=MUL, 3=DIV.
- rs1_reg_val  input  DATA_W  first operand (dividend, multiplicand).
- rs2_reg_val  input  DATA_W  second operand (divisor, multiplier).
- rd_tag_in  input  TAG_W  destination tag.
- out_valid  output  1  result held valid.
- out_ready  input  1  writeback accepts result.
- result  output  DATA_W  operation result.
- rd_tag_out  output  TAG_W  tag of the completed operation.
- div_by_zero  output  1  set with result when a DIV had rs2==0.

Behaviour:
- Reset, asserted at any time including mid-operation:
  - State goes to IDLE and any in-flight operation is discarded; it is not completed later.
  - out_valid, result, rd_tag_out, div_by_zero, iteration counter and internal accumulators all go to 0.
  - in_ready is 1 once rst deasserts.
- States: IDLE, MUL, DIV, DONE.
- Accept: the edge where in_valid && in_ready, called T0. Operands, opcode and tag are latched at T0; the inputs are don't-care afterwards.
- Transitions out of IDLE on accept:
  - ADD/SUB → DONE at T0. out_valid is high in the cycle after T0 (latency 1).
  - MUL → MUL, counter=0.
  - DIV with rs2!=0 → DIV, counter=0.
  - DIV with rs2==0 → DONE at T0 (latency 1).
- MUL/DIV iteration:
  - One iteration per edge while in the state. The counter increments each iteration.
  - On the edge where counter==DATA_W-1, state goes to DONE. out_valid rises after edge T0+DATA_W, i.e. DATA_W-cycle latency (16 by default).
- Arithmetic, all unsigned:
  - ADD = (rs1+rs2) mod 2^DATA_W.
  - SUB = (rs1-rs2) mod 2^DATA_W.
  - MUL = low DATA_W bits of rs1*rs2.
  - DIV = floor(rs1/rs2). The remainder is not output.
  - DIV by zero: result = all ones, div_by_zero=1.
  - div_by_zero = 0 for every other result.
- DONE:
  - result, rd_tag_out and div_by_zero are held stable while out_valid=1 && out_ready=0, for any number of cycles.
  - On out_valid && out_ready, go to IDLE; out_valid drops the next cycle.
  - in_ready rises in that same next cycle. There is no same-cycle bypass, so back-to-back single-cycle ops issue every 2 cycles.
- in_valid while busy: ignored, no latching. The upstream stage must hold the operation until in_ready.
- Opcode, rs1/rs2 and tag changes while busy: no effect on the in-flight result.
- Invalid states are not reachable; a default transition returns to IDLE.

Test Plan:
- Reset: assert rst mid-MUL (counter=7) → next cycle out_valid=0, result=0, in_ready=1 after release; the following ADD 2+3 gives 5 with no residue of the aborted MUL.
- ADD/SUB wrap: ADD 0xFFFF+0x0002 tag 5 → result 0x0001, rd_tag_out=5, out_valid one cycle after accept. SUB 0x0003-0x0005 → 0xFFFE.
- MUL: 0x0123*0x0045 → 0x4E6F, out_valid exactly 16 cycles after accept, in_ready=0 throughout. 0xFFFF*0xFFFF → 0x0001.
- DIV: 1000/7 → 142 (0x008E) after 16 cycles, div_by_zero=0. 5/9 → 0. 0xFFFF/1 → 0xFFFF.
- DIV by zero: 0x1234/0 → result 0xFFFF, div_by_zero=1, latency 1. The next op ADD 1+1 → 2, div_by_zero=0.
- Back-pressure: hold out_ready=0 for 10 cycles after MUL 3*4 → result stays 0x000C, out_valid stays 1, and in_valid pulses during the hold are ignored. On release, completion is followed by in_ready=1 on the next cycle.
